secam_line_control: RTL
=======================

Name: secam_line_control

Overview:
- Upstream timing and sequencing stage for the SECAM chroma encoder.
- Per line, generates the Db/Dr alternation flag (even_line), the carrier gate (enabled) and gated colour-difference samples (yuv_u/yuv_v) for the encoder.
- Sits between the video timing generator and RGB→YUV conversion on the input side, and the SECAM encoder on the output side.
- Outside active video, chroma outputs are forced to 0 so the encoder emits the undeviated reference carrier.

Parameters:
- CHROMA_START, 400: clocks after newline where carrier gate opens (reference carrier begins).
- ACTIVE_START, 500: clocks after newline where colour samples are passed through.
- ACTIVE_END, 2900: first clock after newline where colour samples are forced to 0 again.
- CHROMA_END, 2950: first clock after newline where carrier gate closes.
- Legal only if 0 < CHROMA_START < ACTIVE_START < ACTIVE_END <= CHROMA_END < 4095. Violation is a static elaboration assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- newline  in  1  one-cycle pulse at start of every line (hsync leading edge)
- newframe  in  1  one-cycle pulse at start of every field
- line_visible  in  1  current line carries picture; sampled only on newline
- yuv_u_in  in  8 signed  Db component from colour conversion
- yuv_v_in  in  8 signed  Dr component from colour conversion
- even_line  out  1  1 = Db line, 0 = Dr line
- enabled  out  1  carrier gate to encoder
- yuv_u  out  8 signed  gated Db
- yuv_v  out  8 signed  gated Dr

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, rst_n, sampled on posedge clk.
- Reset values:
  - pos = 4095 (saturated), state = OFF.
  - frame_parity = 0, even_line = 0, enabled = 0.
  - yuv_u = 0, yuv_v = 0.
  - Reset has priority over every other input in the same cycle.
- pos counter (12 bit):
  - On newline, pos := 0.
  - Otherwise pos := pos + 1, saturating at 4095 (no wrap).
  - A missing newline leaves the block idle after CHROMA_END; it never re-enables spontaneously.
- vis register: loaded from line_visible on newline, held otherwise. Reset value 0.
- State machine (next state computed from the registered pos and vis):
  - OFF: carrier off.
  - PRE: waiting; entered on newline when line_visible = 1, otherwise OFF.
  - REF: pos in [CHROMA_START, ACTIVE_START).
  - ACT: pos in [ACTIVE_START, ACTIVE_END).
  - POST: pos in [ACTIVE_END, CHROMA_END).
  - Transitions: PRE→REF when pos == CHROMA_START−1; REF→ACT when pos == ACTIVE_START−1; ACT→POST when pos == ACTIVE_END−1; POST→OFF when pos == CHROMA_END−1.
  - If ACTIVE_END == CHROMA_END, ACT→OFF directly.
  - newline in any state restarts at PRE or OFF (mid-line restart is legal).
- Outputs are registered, valid in the cycle where state holds the named value:
  - enabled = 1 in REF, ACT and POST.
  - yuv_u/yuv_v = input sample from the previous cycle while in ACT, else 0. Total input→output latency is 1 clock.
  - Resulting timing: with newline in cycle 0, enabled first rises in cycle CHROMA_START+1 and falls in cycle CHROMA_END+1.
- even_line / frame parity:
  - On newline without newframe: even_line := ~even_line. Lines alternate through blanking too.
  - On newframe: frame_parity := ~frame_parity, and even_line := new frame_parity value. Consecutive fields therefore start on opposite colour lines.
  - newframe together with newline in the same cycle: newframe rule wins (no extra toggle); pos and state still restart.
  - even_line changes only on these events, never mid-line.
- No arithmetic on the colour data; pass-through or zero only, sign preserved.

Test Plan:
1. Reset: hold rst_n = 0 for 5 clocks with random inputs → all outputs 0. Release, no newline for 5000 clocks → enabled stays 0.
2. Visible line: newline at cycle 0, line_visible = 1, yuv_u_in = −20, yuv_v_in = 35 constant → enabled = 1 in cycles 401..2950. yuv_u = −20 and yuv_v = 35 in cycles 501..2900. Both are 0 in cycles 401..500 and 2901..2950.
3. Blank line: newline with line_visible = 0 → enabled = 0 for the whole line; even_line still toggles.
4. Parity: newframe, then 4 newlines, then newframe, then newline → even_line sequence 1,0,1,0,1 in field 1; then 0,1 in field 2. A simultaneous newframe+newline yields the parity value with no extra toggle.
5. Mid-line restart: second newline at pos = 1000 during ACT → outputs 0 and enabled = 0 from the next cycle; enabled re-asserts CHROMA_START+1 cycles after the second newline.
6. Reset mid-line: rst_n = 0 at pos = 700 → next cycle all outputs 0, state OFF, even_line = 0.

Source files
------------

// File: rtl/secam_line_control.sv
`default_nettype none
// ============================================================================
// Module      : secam_line_control
// Description : Per-line sequencing for the SECAM chroma encoder. Tracks the
//               position within the line, opens and closes the carrier gate,
//               passes colour-difference samples only during active video and
//               maintains the Db/Dr line alternation across fields.
// Revision    : 1.0 - initial release
// ============================================================================
module secam_line_control #(
  parameter int CHROMA_START = 400,
  parameter int ACTIVE_START = 500,
  parameter int ACTIVE_END   = 2900,
  parameter int CHROMA_END   = 2950
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newline,
  input  logic              newframe,
  input  logic              line_visible,
  input  logic signed [7:0] yuv_u_in,
  input  logic signed [7:0] yuv_v_in,
  output logic              even_line,
  output logic              enabled,
  output logic signed [7:0] yuv_u,
  output logic signed [7:0] yuv_v
);

  // Timing window boundaries expressed as the last pos value of each phase,
  // so each transition fires exactly one clock before the phase boundary.
  localparam logic [11:0] c_pos_max  = 12'hFFF;
  localparam logic [11:0] c_pre_last = 12'(CHROMA_START - 1);
  localparam logic [11:0] c_ref_last = 12'(ACTIVE_START - 1);
  localparam logic [11:0] c_act_last = 12'(ACTIVE_END - 1);
  localparam logic [11:0] c_pst_last = 12'(CHROMA_END - 1);
  // With no post-active guard band the active phase ends directly in OFF.
  localparam logic        c_no_post  = (ACTIVE_END == CHROMA_END);

  // Static legality check on the timing window ordering.
  generate
    if (!((0 < CHROMA_START) && (CHROMA_START < ACTIVE_START) &&
          (ACTIVE_START < ACTIVE_END) && (ACTIVE_END <= CHROMA_END) &&
          (CHROMA_END < 4095))) begin : g_param_check
      $error("secam_line_control: illegal timing window parameters");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_PRE  = 3'd1,
    ST_REF  = 3'd2,
    ST_ACT  = 3'd3,
    ST_POST = 3'd4
  } state_t;

  logic [11:0] r_pos;
  logic        r_vis;
  logic        r_frame_parity;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gate_nxt;
  logic        w_act_nxt;

  // Line position counter (saturating) and per-line visibility latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos <= c_pos_max;
      r_vis <= 1'b0;
    end else if (newline) begin
      r_pos <= 12'd0;
      r_vis <= line_visible;
    end else if (r_pos != c_pos_max) begin
      r_pos <= r_pos + 12'd1;
    end
  end

  // Next-state decode from the registered position; newline always restarts.
  always_comb begin
    w_state_nxt = r_state;
    if (newline) begin
      w_state_nxt = line_visible ? ST_PRE : ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:  w_state_nxt = ST_OFF;
        ST_PRE: begin
          if (!r_vis)
            w_state_nxt = ST_OFF;
          else if (r_pos == c_pre_last)
            w_state_nxt = ST_REF;
        end
        ST_REF: begin
          if (r_pos == c_ref_last)
            w_state_nxt = ST_ACT;
        end
        ST_ACT: begin
          if (r_pos == c_act_last)
            w_state_nxt = c_no_post ? ST_OFF : ST_POST;
        end
        ST_POST: begin
          if (r_pos == c_pst_last)
            w_state_nxt = ST_OFF;
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Output qualifiers are derived from the upcoming state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_gate_nxt = (w_state_nxt == ST_REF) || (w_state_nxt == ST_ACT) ||
                 (w_state_nxt == ST_POST);
    w_act_nxt  = (w_state_nxt == ST_ACT);
  end

  // State register with registered carrier gate and gated chroma samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      enabled <= 1'b0;
      yuv_u   <= 8'sd0;
      yuv_v   <= 8'sd0;
    end else begin
      r_state <= w_state_nxt;
      enabled <= w_gate_nxt;
      yuv_u   <= w_act_nxt ? yuv_u_in : 8'sd0;
      yuv_v   <= w_act_nxt ? yuv_v_in : 8'sd0;
    end
  end

  // Db/Dr alternation: toggles every line, re-seeded from the field parity
  // on each new field so consecutive fields start on opposite colour lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_parity <= 1'b0;
      even_line      <= 1'b0;
    end else if (newframe) begin
      r_frame_parity <= ~r_frame_parity;
      even_line      <= ~r_frame_parity;
    end else if (newline) begin
      even_line      <= ~even_line;
    end
  end

endmodule
`default_nettype wire
